keep_one_in_n_unzip: RTL and testbench

Downstream companion to the 4:1 symbol packer. Each accepted 32-bit packed word holds four 8-bit symbols, and each symbol byte is 4-bit I in [7:4] and 4-bit Q in [3:0]. The block expands every packed word into four 32-bit {I16,Q16} samples, restoring the sample rate on the receive-side RFNoC stream. It carries packet framing (tlast) through and applies full AXI-Stream backpressure on both sides.

---
 rtl/keep_one_in_n_unzip.sv | 102 ++++++++++
 tb/tb_keep_one_in_n_unzip.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keep_one_in_n_unzip.sv
// Expands each packed word of four 4-bit I/Q symbol bytes into four {I16,Q16} samples.
// Packet framing is carried through, and AXI-Stream backpressure applies on both sides.
module keep_one_in_n_unzip #(
   parameter int WIDTH       = 32,
   parameter int EXPAND_MODE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready
);

   logic             full_r;
   logic [1:0]       slot_r;
   logic [WIDTH-1:0] word_r;
   logic             last_r;

   logic             full_s;
   logic [1:0]       slot_s;
   logic [WIDTH-1:0] word_s;
   logic             last_s;
   logic             accept_s;
   logic             fire_s;

   function automatic logic [15:0] widen(input logic [3:0] nib);
      if (EXPAND_MODE == 1) begin
         widen = {{12{nib[3]}}, nib};
      end else begin
         widen = {nib, 12'h000};
      end
   endfunction

   // The slot order matches the packer: 0=[31:24], 1=[7:0], 2=[15:8], 3=[23:16].
   function automatic logic [7:0] pick(input logic [WIDTH-1:0] w, input logic [1:0] s);
      case (s)
         2'd0:    pick = w[31:24];
         2'd1:    pick = w[7:0];
         2'd2:    pick = w[15:8];
         2'd3:    pick = w[23:16];
         default: pick = 8'h00;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] expand(input logic [7:0] b);
      expand = {widen(b[7:4]), widen(b[3:0])};
   endfunction

   assign i_tready = ~full_r | (o_tready & (slot_r == 2'd3));
   assign accept_s = i_tvalid & i_tready;
   assign fire_s   = full_r & o_tready;

   // Next-state selection. An accept while full can only coincide with the slot-3 handshake.
   always_comb begin
      full_s = full_r;
      slot_s = slot_r;
      word_s = word_r;
      last_s = last_r;
      if (accept_s) begin
         word_s = i_tdata;
         last_s = i_tlast;
         slot_s = 2'd0;
         full_s = 1'b1;
      end else if (fire_s) begin
         if (slot_r == 2'd3) begin
            full_s = 1'b0;
            slot_s = 2'd0;
         end else begin
            slot_s = slot_r + 2'd1;
         end
      end else begin
         full_s = full_r;
      end
   end

   // State and output registers. The outputs are precomputed from the next state, so they stay registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r   <= 1'b0;
         slot_r   <= 2'd0;
         word_r   <= '0;
         last_r   <= 1'b0;
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
         o_tdata  <= '0;
      end else begin
         full_r   <= full_s;
         slot_r   <= slot_s;
         word_r   <= word_s;
         last_r   <= last_s;
         o_tvalid <= full_s;
         o_tlast  <= full_s & last_s & (slot_s == 2'd3);
         o_tdata  <= expand(pick(word_s, slot_s));
      end
   end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Directed bench for keep_one_in_n_unzip: MSB-aligned and sign-extended instances share one stimulus.
module tb_keep_one_in_n_unzip;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        o_tready;
   logic        i_tready, i_tready_m1;
   logic [31:0] o_tdata, o_tdata_m1;
   logic        o_tlast, o_tlast_m1;
   logic        o_tvalid, o_tvalid_m1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   keep_one_in_n_unzip #(.WIDTH(32), .EXPAND_MODE(0)) dut (
      .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
      .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready));

   keep_one_in_n_unzip #(.WIDTH(32), .EXPAND_MODE(1)) dut_m1 (
      .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready_m1), .o_tdata(o_tdata_m1),
      .o_tlast(o_tlast_m1), .o_tvalid(o_tvalid_m1), .o_tready(o_tready));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one word, waits for it to be accepted, then checks the four samples with o_tready held high.
   task automatic run_word(input logic [31:0] w, input logic l, input logic [127:0] e,
                           input logic el, input logic m1);
      int n;
      i_tdata  = w;
      i_tlast  = l;
      i_tvalid = 1'b1;
      o_tready = 1'b1;
      #1;
      n = 0;
      while (!(m1 ? i_tready_m1 : i_tready) && n < 20) begin
         step();
         n++;
      end
      check("accept", {31'd0, (m1 ? i_tready_m1 : i_tready)}, 32'd1);
      step();
      i_tvalid = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("valid", {31'd0, (m1 ? o_tvalid_m1 : o_tvalid)}, 32'd1);
         check("data", (m1 ? o_tdata_m1 : o_tdata), e[127-32*k -: 32]);
         check("last", {31'd0, (m1 ? o_tlast_m1 : o_tlast)}, {31'd0, (k == 3) ? el : 1'b0});
         step();
      end
      check("drain", {31'd0, (m1 ? o_tvalid_m1 : o_tvalid)}, 32'd0);
   endtask

   initial begin
      int  wi;
      logic acc;
      reset    = 1'b1;
      i_tdata  = 32'h0;
      i_tlast  = 1'b0;
      i_tvalid = 1'b0;
      o_tready = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_valid", {31'd0, o_tvalid}, 32'd0);
      check("rst_last",  {31'd0, o_tlast},  32'd0);
      check("rst_data",  o_tdata,           32'h0);
      check("rst_ready", {31'd0, i_tready}, 32'd1);

      // Basic expansion, MSB-aligned
      run_word(32'h12345678, 1'b0,
               {32'h10002000, 32'h70008000, 32'h50006000, 32'h30004000}, 1'b0, 1'b0);

      // Sign extension: byte 0x11 in slot 1 gives 0x0001 on both rails
      run_word(32'hF87F0011, 1'b0,
               {32'hFFFFFFF8, 32'h00010001, 32'h00000000, 32'h0007FFFF}, 1'b0, 1'b1);

      // Framing: tlast on the third word, asserted only on sample 12
      run_word(32'h12345678, 1'b0,
               {32'h10002000, 32'h70008000, 32'h50006000, 32'h30004000}, 1'b0, 1'b0);
      run_word(32'hF87F0011, 1'b0,
               {32'hF0008000, 32'h10001000, 32'h00000000, 32'h7000F000}, 1'b0, 1'b0);
      run_word(32'hAABBCCDD, 1'b1,
               {32'hA000A000, 32'hD000D000, 32'hC000C000, 32'hB000B000}, 1'b1, 1'b0);

      // Backpressure during slot 1, with the next word waiting
      i_tdata  = 32'h12345678;
      i_tlast  = 1'b0;
      i_tvalid = 1'b1;
      o_tready = 1'b1;
      step();
      i_tvalid = 1'b0;
      #1;
      check("bp_s0", o_tdata, 32'h10002000);
      step();
      o_tready = 1'b0;
      i_tvalid = 1'b1;
      i_tdata  = 32'h9ABCDEF0;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_data",  o_tdata,           32'h70008000);
         check("bp_hold_ready", {31'd0, i_tready}, 32'd0);
         check("bp_hold_valid", {31'd0, o_tvalid}, 32'd1);
         step();
      end
      o_tready = 1'b1;
      #1;
      check("bp_s1", o_tdata, 32'h70008000);
      check("bp_s1_ready", {31'd0, i_tready}, 32'd0);
      step();
      check("bp_s2", o_tdata, 32'h50006000);
      check("bp_s2_ready", {31'd0, i_tready}, 32'd0);
      step();
      check("bp_s3", o_tdata, 32'h30004000);
      check("bp_s3_ready", {31'd0, i_tready}, 32'd1);
      step();
      i_tvalid = 1'b0;
      #1;
      check("bp_nobubble", {31'd0, o_tvalid}, 32'd1);
      check("bp_w2_s0", o_tdata, 32'h9000A000);
      step();
      check("bp_w2_s1", o_tdata, 32'hF0000000);
      step();
      check("bp_w2_s2", o_tdata, 32'hD000E000);
      step();
      check("bp_w2_s3", o_tdata, 32'hB000C000);
      step();
      check("bp_drain", {31'd0, o_tvalid}, 32'd0);

      // Back-to-back streaming of four words
      wi       = 0;
      i_tdata  = 32'h11111111;
      i_tvalid = 1'b1;
      o_tready = 1'b1;
      #1;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) begin
            check("b2b_valid", {31'd0, o_tvalid}, 32'd1);
            check("b2b_data", o_tdata, 32'h10001000 * (((c - 1) / 4) + 1));
         end
         check("b2b_ready", {31'd0, i_tready}, {31'd0, (c % 4) == 0});
         acc = i_tready & i_tvalid;
         step();
         if (acc) begin
            wi++;
            if (wi < 4) i_tdata = 32'h11111111 * (wi + 1);
            else i_tvalid = 1'b0;
         end
      end
      check("b2b_drain", {31'd0, o_tvalid}, 32'd0);

      // Mid-word reset discards the remaining slots
      i_tdata  = 32'hAABBCCDD;
      i_tlast  = 1'b1;
      i_tvalid = 1'b1;
      o_tready = 1'b1;
      step();
      i_tvalid = 1'b0;
      #1;
      check("mr_s0", o_tdata, 32'hA000A000);
      step();
      check("mr_s1", o_tdata, 32'hD000D000);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("mr_valid", {31'd0, o_tvalid}, 32'd0);
      check("mr_data",  o_tdata,           32'h0);
      check("mr_ready", {31'd0, i_tready}, 32'd1);
      run_word(32'h11111111, 1'b0,
               {32'h10001000, 32'h10001000, 32'h10001000, 32'h10001000}, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
